// File: rtl/lsu_wb_master_if.sv
// Pipelined Wishbone data-port bundle between the load/store unit and main_memory.
// Latency: none, wires only.
// Backpressure: the slave holds off a strobe with stall; completion is signalled by ack.
// Signals: cyc, stb, wr_en, addr, wr_data, wr_sel (master -> slave);
//          ack, stall, rd_data (slave -> master).
interface lsu_wb_master_if;
  logic        cyc;
  logic        stb;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_sel;
  logic        ack;
  logic        stall;
  logic [31:0] rd_data;

  modport master (
    output cyc, stb, wr_en, addr, wr_data, wr_sel,
    input  ack, stall, rd_data
  );

  modport slave (
    input  cyc, stb, wr_en, addr, wr_data, wr_sel,
    output ack, stall, rd_data
  );
endinterface

// File: rtl/lsu_wb_master.sv
// RV32I MEM-stage load/store initiator: one request -> one pipelined Wishbone transfer.
// Latency: 2 cycles accept-to-response with a zero-wait slave (+1 per stall); illegal requests respond next cycle.
// Backpressure: req_ready only in IDLE; wb.stall holds the strobe; TIMEOUT_CYCLES aborts a silent slave.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_wr/req_funct3/req_addr/req_wr_data
//        request side; rsp_valid/rsp_rd_data/rsp_err response pulse; busy; wb = Wishbone master bundle.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wr_data,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rd_data,
  output logic             rsp_err,
  output logic             busy,
  lsu_wb_master_if.master  wb
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STROBE   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [1:0]  state;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        req_illegal;

  // Byte-lane select from access size and low address bits; loads use the same lanes.
  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_sel = 4'b0001 << a;
      2'b01:   lane_sel = 4'b0011 << {a[1], 1'b0};
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the slave picks it up under any select.
  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_rep = {4{d[7:0]}};
      2'b01:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = d >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = d;
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = 32'd0;
    endcase
  endfunction

  always_comb begin
    req_illegal = 1'b0;
    if (req_wr) begin
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      req_illegal = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      req_illegal = 1'b1;
    end
  end

  // tmo_cnt counts cycles already spent with cyc high; the abort fires on the edge
  // that would make it TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after cyc rose.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((tmo_cnt + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdat_q      <= 32'd0;
      sel_q       <= 4'd0;
      tmo_cnt     <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rd_data <= 32'd0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rd_data <= 32'd0;
      if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tmo_cnt <= 32'd0;
            if (req_illegal) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state  <= ST_STROBE;
              wr_q   <= req_wr;
              f3_q   <= req_funct3;
              addr_q <= req_addr;
              sel_q  <= lane_sel(req_funct3, req_addr[1:0]);
              // Loads keep the write-data lanes at zero.
              wdat_q <= req_wr ? store_rep(req_funct3, req_wr_data) : 32'd0;
            end
          end
        end
        ST_STROBE: begin
          if (!wb.stall && wb.ack) begin
            state       <= ST_IDLE;
            rsp_valid   <= 1'b1;
            rsp_rd_data <= wr_q ? 32'd0 : load_extract(f3_q, addr_q[1:0], wb.rd_data);
          end else if (tmo_hit) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (!wb.stall) begin
            state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (wb.ack) begin
            state       <= ST_IDLE;
            rsp_valid   <= 1'b1;
            rsp_rd_data <= wr_q ? 32'd0 : load_extract(f3_q, addr_q[1:0], wb.rd_data);
          end else if (tmo_hit) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs come straight from state so an async reset drops cyc/stb at once;
  // the latched fields are gated so the bus reads zero between transfers.
  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign wb.cyc     = busy;
  assign wb.stb     = (state == ST_STROBE);
  assign wb.wr_en   = busy & wr_q;
  assign wb.addr    = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign wb.wr_data = busy ? wdat_q : 32'd0;
  assign wb.wr_sel  = busy ? sel_q : 4'd0;

endmodule
